// File: rtl/gnw_audio_mix.sv
// gnw_audio_mix: N-channel melody mixer for the Game & Watch core.
// Each 1-bit melody line is scaled by its 4-bit volume. The scaled lines are
// summed into a target level. A one-pole slew limiter moves an accumulator
// toward that target once per output strobe. The result is emitted as a
// registered PCM sample with a one-cycle sample_valid pulse.
module gnw_audio_mix #(
   parameter int CHANNELS   = 2,     // melody channels, 1..8
   parameter int OUT_W      = 16,    // PCM width, 12..24
   parameter int CLK_DIV    = 2083,  // clk_sys cycles per output sample, >= 2
   parameter int SLEW_SHIFT = 4,     // step = diff >>> SLEW_SHIFT
   parameter int SIGNED_OUT = 0      // 0: unsigned sample, 1: two's complement with MSB 0
) (
   input  logic                    clk_sys,
   input  logic                    reset,
   input  logic [CHANNELS-1:0]     melody,
   input  logic [4*CHANNELS-1:0]   vol,
   input  logic                    mute,
   output logic [OUT_W-1:0]        audio_out,
   output logic                    sample_valid
);

   // Per-channel headroom: the full-scale sum of all channels still fits in OUT_W-1 bits.
   localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 0;
   localparam int LVL_SH  = OUT_W - 5 - CH_BITS;
   localparam int ACC_W   = OUT_W - 1;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   // Scaled level of one channel; silent when the tone is low or muted.
   function automatic logic [ACC_W-1:0] chan_level(input logic [3:0] v, input logic on);
      chan_level = on ? (ACC_W'(v) << LVL_SH) : '0;
   endfunction

   // One slew step toward the target.
   // The shifted difference is forced to at least +/-1 so the accumulator always lands exactly.
   // |step| <= |diff| always holds, so the accumulator cannot overshoot.
   // Because of that, modulo-ACC_W addition is exact.
   function automatic logic [ACC_W-1:0] slew_next(input logic [ACC_W-1:0] acc,
                                                  input logic [ACC_W-1:0] tgt);
      logic signed [OUT_W:0] diff;
      logic signed [OUT_W:0] raw;
      logic [ACC_W-1:0]      step;
      diff = $signed({2'b00, tgt}) - $signed({2'b00, acc});
      raw  = diff >>> SLEW_SHIFT;
      if ((raw == '0) && (diff != '0)) begin
         step = diff[OUT_W] ? '1 : ACC_W'(1);
      end else begin
         step = raw[ACC_W-1:0];
      end
      slew_next = acc + step;
   endfunction

   // Map the unsigned accumulator onto the output sample format.
   function automatic logic [OUT_W-1:0] format_out(input logic [ACC_W-1:0] acc);
      if (SIGNED_OUT != 0) begin
         format_out = {1'b0, acc};
      end else begin
         format_out = {acc, 1'b0};
      end
   endfunction

   logic [CHANNELS-1:0]   melody_q, melody_d;
   logic [4*CHANNELS-1:0] vol_q, vol_d;
   logic                  mute_q, mute_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [OUT_W-1:0]      audio_q, audio_d;
   logic                  valid_q, valid_d;
   logic [ACC_W-1:0]      target;
   logic                  tick;

   // Mix: sum the registered channel levels into the target; mute wins over any tone.
   always_comb begin
      target = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         target = target + chan_level(vol_q[4*i +: 4], melody_q[i] & ~mute_q);
      end
   end

   // Next state: strobe divider, slew update on tick, and the output sample one cycle after tick.
   always_comb begin
      melody_d = melody;
      vol_d    = vol;
      mute_d   = mute;
      tick     = (div_q == DIV_LAST);
      div_d    = tick ? '0 : div_q + DIV_W'(1);
      acc_d    = tick ? slew_next(acc_q, target) : acc_q;
      audio_d  = tick ? format_out(acc_d) : audio_q;
      valid_d  = tick;
   end

   // State registers; reset returns every stage, including the input capture, to silence.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         melody_q <= '0;
         vol_q    <= '0;
         mute_q   <= 1'b0;
         div_q    <= '0;
         acc_q    <= '0;
         audio_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         melody_q <= melody_d;
         vol_q    <= vol_d;
         mute_q   <= mute_d;
         div_q    <= div_d;
         acc_q    <= acc_d;
         audio_q  <= audio_d;
         valid_q  <= valid_d;
      end
   end

   assign audio_out    = audio_q;
   assign sample_valid = valid_q;

endmodule

// File: tb/tb_gnw_audio_mix.sv
// Bench for gnw_audio_mix: two instances share the stimulus.
//   dut_a: SLEW_SHIFT=4, unsigned output.
//   dut_b: SLEW_SHIFT=0, signed output.
// A per-sample arithmetic reference model predicts both outputs.
module tb_gnw_audio_mix;

   localparam int CLK_DIV = 23;
   localparam int LSH     = 10;   // OUT_W-5-CH_BITS for OUT_W=16, 2 channels

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mel;
   logic [7:0]  vl;
   logic        mt;
   logic [15:0] aout_a, aout_b;
   logic        sv_a, sv_b;
   logic [15:0] prev;

   int n_cmp = 0;
   int n_err = 0;
   int acc_a = 0;
   int acc_b = 0;

   always #5 clk = ~clk;

   gnw_audio_mix #(.CHANNELS(2), .OUT_W(16), .CLK_DIV(CLK_DIV), .SLEW_SHIFT(4), .SIGNED_OUT(0)) dut_a (
      .clk_sys(clk), .reset(rst), .melody(mel), .vol(vl), .mute(mt),
      .audio_out(aout_a), .sample_valid(sv_a));

   gnw_audio_mix #(.CHANNELS(2), .OUT_W(16), .CLK_DIV(CLK_DIV), .SLEW_SHIFT(0), .SIGNED_OUT(1)) dut_b (
      .clk_sys(clk), .reset(rst), .melody(mel), .vol(vl), .mute(mt),
      .audio_out(aout_b), .sample_valid(sv_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Target level: sum of volume*1024 over sounding channels, 0 when muted.
   function automatic int target_of(input logic [1:0] m, input logic [7:0] v, input logic mu);
      int t;
      t = 0;
      if (!mu) begin
         for (int i = 0; i < 2; i++) begin
            if (m[i]) t += int'(v[4*i +: 4]) * (1 << LSH);
         end
      end
      return t;
   endfunction

   // Floor(diff / 2^sh), at least one unit toward the target when not yet there.
   function automatic int step_of(input int diff, input int sh);
      int d, s;
      if (sh == 0) return diff;
      d = 1 << sh;
      if (diff >= 0) s = diff / d;
      else           s = -((-diff + d - 1) / d);
      if (s == 0 && diff != 0) s = (diff > 0) ? 1 : -1;
      return s;
   endfunction

   // Wait for the next sample_valid pulse, counting active edges; bounded.
   task automatic wait_sample(output int n);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!sv_a && n < 3 * CLK_DIV);
      if (!sv_a) chk("sample_timeout", {31'd0, sv_a}, 32'd1);
   endtask

   task automatic do_sample(input string tag);
      int n, t;
      wait_sample(n);
      chk({tag, "_period"}, n, CLK_DIV);
      t = target_of(mel, vl, mt);
      acc_a += step_of(t - acc_a, 4);
      acc_b += step_of(t - acc_b, 0);
      chk({tag, "_a"}, {16'd0, aout_a}, acc_a * 2);
      chk({tag, "_b"}, {16'd0, aout_b}, acc_b);
      chk({tag, "_svb"}, {31'd0, sv_b}, 32'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with all tones on at full volume
      rst = 1'b1; mel = 2'b11; vl = 8'hFF; mt = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("rst_aout_a", {16'd0, aout_a}, 32'd0);
         chk("rst_sv_a",   {31'd0, sv_a},   32'd0);
         chk("rst_aout_b", {16'd0, aout_b}, 32'd0);
      end

      // Strobe cadence with silence
      rst = 1'b0; mel = 2'b00;
      repeat (4) do_sample("strobe");

      // Step response on channel 0
      mel = 2'b01; vl = 8'h0F;
      do_sample("step1"); chk("step1_lit", {16'd0, aout_a}, 32'd1920);
      chk("step1_b_lit", {16'd0, aout_b}, 32'd15360);
      do_sample("step2"); chk("step2_lit", {16'd0, aout_a}, 32'd3720);
      do_sample("step3"); chk("step3_lit", {16'd0, aout_a}, 32'd5406);
      repeat (250) begin
         do_sample("ramp");
         chk("ramp_noover", {31'd0, aout_a <= 16'd30720}, 32'd1);
      end
      chk("ramp_final", {16'd0, aout_a}, 32'd30720);

      // Full scale, both channels
      mel = 2'b11; vl = 8'hFF;
      repeat (250) begin
         do_sample("full");
         chk("full_noover", {31'd0, aout_a <= 16'd61440}, 32'd1);
      end
      chk("full_a", {16'd0, aout_a}, 32'd61440);
      chk("full_b", {16'd0, aout_b}, 32'd30720);

      // Settle back to half scale, then mute mid-tone
      mel = 2'b01; vl = 8'h0F;
      repeat (250) do_sample("half");
      chk("half_a", {16'd0, aout_a}, 32'd30720);
      mt = 1'b1;
      do_sample("mute1");
      chk("mute1_lit", {16'd0, aout_a}, 32'd28800);
      repeat (250) begin
         prev = aout_a;
         do_sample("mute");
         chk("mute_mono", {31'd0, aout_a <= prev}, 32'd1);
      end
      chk("mute_final", {16'd0, aout_a}, 32'd0);

      // Reset in the middle of a ramp
      mt = 1'b0;
      repeat (12) do_sample("ramp6");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst6_aout_a", {16'd0, aout_a}, 32'd0);
      chk("rst6_sv_a",   {31'd0, sv_a},   32'd0);
      chk("rst6_aout_b", {16'd0, aout_b}, 32'd0);
      acc_a = 0; acc_b = 0;
      do_sample("rst6");
      chk("rst6_lit_a", {16'd0, aout_a}, 32'd1920);
      chk("rst6_lit_b", {16'd0, aout_b}, 32'd15360);

      // Randomized channel/volume/mute patterns
      repeat (8) begin
         mel = 2'($urandom_range(0, 3));
         vl  = 8'($urandom_range(0, 255));
         mt  = ($urandom_range(0, 3) == 0);
         repeat (30) do_sample("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
